uart_rx: RTL and testbench

Serial receiver for the 16550-compatible UART. Consumes the 16× `sample_tick` from the baud generator, oversamples the `sin` line, and recovers start, data, parity and stop bits under LCR control. Each completed character is presented as a one-cycle `rx_valid` strobe with per-character status, which the RX FIFO / LSR logic captures downstream.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: word-length and receiver state enums,
// default oversampling ratio and a word-length decode helper.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  function automatic logic [3:0] wordLen(input wls_t w);
    return 4'd5 + {2'b00, w};
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer with async reset and selectable reset value.
// Also used for modem-status inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16550-style UART receiver: oversamples sin on sample_tick, recovers
// start/data/parity/stop under latched LCR settings and strobes each character.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  sin,
  input  logic [1:0]            wls,
  input  logic                  pen,
  input  logic                  eps,
  input  logic                  stick,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  break_int,
  output logic                  rx_active
);

  localparam int         IDX_W     = $clog2(DATA_WIDTH);
  localparam logic [3:0] HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] BIT_LAST  = 4'(OVERSAMPLE - 1);

  logic                  w_sinS;
  rx_state_t             r_state;
  rx_state_t             w_stateNext;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cntNext;
  logic [3:0]            w_cntInc;
  logic                  w_atSample;
  logic                  w_lastBit;
  logic                  w_breakDet;
  logic                  w_expPar;
  logic [IDX_W-1:0]      r_bitIdx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parBit;
  logic                  r_anyOne;
  wls_t                  r_wls;
  logic                  r_pen;
  logic                  r_eps;
  logic                  r_stick;
  logic [DATA_WIDTH-1:0] r_rxData;
  logic                  r_rxValid;
  logic                  r_parityErr;
  logic                  r_framingErr;
  logic                  r_breakInt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sinSync (
    .clk   (clk),
    .reset (reset),
    .i_d   (sin),
    .o_q   (w_sinS)
  );

  assign w_cntInc   = r_cnt + 4'd1;
  assign w_atSample = sample_tick && (r_cnt == BIT_LAST);
  assign w_lastBit  = (int'(r_bitIdx) == int'(wordLen(r_wls)) - 1);
  assign w_breakDet = !r_anyOne && !w_sinS;
  // Stick parity forces ~eps; otherwise the bit completes even (eps=1) or odd parity.
  assign w_expPar   = r_stick ? ~r_eps : ((^r_shift) ^ ~r_eps);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (sample_tick && !w_sinS) begin
          w_stateNext = START;
          w_cntNext   = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (w_cntInc == HALF_LAST) begin
            w_cntNext   = '0;
            w_stateNext = w_sinS ? IDLE : DATA;
          end else begin
            w_cntNext = w_cntInc;
          end
        end
      end
      DATA, PARITY, STOP: begin
        if (sample_tick) begin
          if (r_cnt == BIT_LAST) begin
            w_cntNext = '0;
            if (r_state == DATA) begin
              if (w_lastBit) w_stateNext = r_pen ? PARITY : STOP;
            end else if (r_state == PARITY) begin
              w_stateNext = STOP;
            end else begin
              w_stateNext = w_breakDet ? BRK_WAIT : IDLE;
            end
          end else begin
            w_cntNext = w_cntInc;
          end
        end
      end
      BRK_WAIT: begin
        if (sample_tick && w_sinS) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitIdx     <= '0;
      r_shift      <= '0;
      r_parBit     <= 1'b0;
      r_anyOne     <= 1'b0;
      r_wls        <= WLS_5;
      r_pen        <= 1'b0;
      r_eps        <= 1'b0;
      r_stick      <= 1'b0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_parityErr  <= 1'b0;
      r_framingErr <= 1'b0;
      r_breakInt   <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (r_state == IDLE && sample_tick && !w_sinS) begin
        r_wls   <= wls_t'(wls);
        r_pen   <= pen;
        r_eps   <= eps;
        r_stick <= stick;
      end
      if (r_state == START && sample_tick && w_cntInc == HALF_LAST && !w_sinS) begin
        r_shift  <= '0;
        r_bitIdx <= '0;
        r_anyOne <= 1'b0;
      end
      if (r_state == DATA && w_atSample) begin
        r_shift[r_bitIdx] <= w_sinS;
        r_bitIdx          <= r_bitIdx + 1'b1;
        if (w_sinS) r_anyOne <= 1'b1;
      end
      if (r_state == PARITY && w_atSample) begin
        r_parBit <= w_sinS;
        if (w_sinS) r_anyOne <= 1'b1;
      end
      if (r_state == STOP && w_atSample) begin
        r_rxValid    <= 1'b1;
        r_rxData     <= r_shift;
        r_parityErr  <= r_pen && (r_parBit != w_expPar);
        r_framingErr <= !w_sinS;
        r_breakInt   <= w_breakDet;
      end
    end
  end

  assign rx_data     = r_rxData;
  assign rx_valid    = r_rxValid;
  assign parity_err  = r_parityErr;
  assign framing_err = r_framingErr;
  assign break_int   = r_breakInt;
  assign rx_active   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected characters,
// a negedge monitor pops and compares on every rx_valid strobe.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic       sin;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       stick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       break_int;
  logic       rx_active;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       chkLat;
    int         startTick;
  } exp_t;

  exp_t expQ[$];
  exp_t popped;
  int   checks    = 0;
  int   failures  = 0;
  int   tickCount = 0;
  int   tickPhase = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .sin         (sin),
    .wls         (wls),
    .pen         (pen),
    .eps         (eps),
    .stick       (stick),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .break_int   (break_int),
    .rx_active   (rx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sample_tick every 4 clocks, changed just after the rising edge.
  initial sample_tick = 1'b0;
  always @(posedge clk) begin
    #1;
    sample_tick = (tickPhase == 3);
    tickPhase   = (tickPhase + 1) % 4;
  end

  always @(posedge clk) begin
    if (sample_tick === 1'b1) tickCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && rx_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe actual rx_data=%02h expected no strobe", rx_data);
      end else begin
        popped = expQ.pop_front();
        checkOutput("rx_data", 32'(rx_data), 32'(popped.data));
        checkOutput("parity_err", 32'(parity_err), 32'(popped.perr));
        checkOutput("framing_err", 32'(framing_err), 32'(popped.ferr));
        checkOutput("break_int", 32'(break_int), 32'(popped.brk));
        if (popped.chkLat) checkOutput("strobe_latency", 32'(tickCount - popped.startTick), 32'd152);
      end
    end
  end

  task automatic waitTicks(input int n);
    repeat (n) begin
      do @(posedge clk); while (sample_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int nBits, input logic usePar,
                               input logic parBit, input logic stopLow, input logic [7:0] eData,
                               input logic ePerr, input logic eFerr, input logic chkLat);
    exp_t item;
    waitTicks(1);
    sin            = 1'b0;
    item.data      = eData;
    item.perr      = ePerr;
    item.ferr      = eFerr;
    item.brk       = 1'b0;
    item.chkLat    = chkLat;
    item.startTick = tickCount;
    expQ.push_back(item);
    waitTicks(16);
    for (int i = 0; i < nBits; i++) begin
      sin = data[i];
      waitTicks(16);
    end
    if (usePar) begin
      sin = parBit;
      waitTicks(16);
    end
    if (stopLow) begin
      sin = 1'b0;
      waitTicks(8);
      sin = 1'b1;
      waitTicks(8);
    end else begin
      sin = 1'b1;
      waitTicks(16);
    end
    waitTicks(4);
  endtask

  initial begin
    exp_t brkItem;
    reset = 1'b1;
    sin   = 1'b1;
    wls   = 2'b11;
    pen   = 1'b0;
    eps   = 1'b0;
    stick = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset_rx_active", 32'(rx_active), 32'd0);
    checkOutput("reset_flags", 32'({parity_err, framing_err, break_int}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitTicks(4);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);

    $display("[TB] 7E1 0x41 parity wrong then correct");
    wls = 2'b10; pen = 1'b1; eps = 1'b1;
    applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);

    $display("[TB] false start");
    wls = 2'b11; pen = 1'b0; eps = 1'b0;
    waitTicks(1);
    sin = 1'b0;
    waitTicks(3);
    checkOutput("false_start_active", 32'(rx_active), 32'd1);
    sin = 1'b1;
    waitTicks(10);
    checkOutput("false_start_idle", 32'(rx_active), 32'd0);

    $display("[TB] framing error then clean frame");
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    waitTicks(4);
    applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);

    $display("[TB] break");
    waitTicks(1);
    sin               = 1'b0;
    brkItem.data      = 8'h00;
    brkItem.perr      = 1'b0;
    brkItem.ferr      = 1'b1;
    brkItem.brk       = 1'b1;
    brkItem.chkLat    = 1'b0;
    brkItem.startTick = tickCount;
    expQ.push_back(brkItem);
    waitTicks(320);
    checkOutput("break_wait_active", 32'(rx_active), 32'd1);
    sin = 1'b1;
    waitTicks(4);
    checkOutput("break_release_idle", 32'(rx_active), 32'd0);

    $display("[TB] 5-bit stick parity");
    wls = 2'b00; pen = 1'b1; stick = 1'b1; eps = 1'b0;
    applyStimulus(8'h15, 5, 1'b1, 1'b1, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    waitTicks(1);
    sin = 1'b0;
    waitTicks(16);
    sin = 1'b1;
    waitTicks(16);
    sin = 1'b0;
    waitTicks(8);
    checkOutput("mid_frame_active", 32'(rx_active), 32'd1);
    reset = 1'b1;
    sin   = 1'b1;
    #2;
    checkOutput("abort_rx_active", 32'(rx_active), 32'd0);
    checkOutput("abort_rx_data", 32'(rx_data), 32'd0);
    checkOutput("abort_outputs", 32'({rx_valid, parity_err, framing_err, break_int}), 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    waitTicks(40);
    checkOutput("post_reset_idle", 32'(rx_active), 32'd0);

    checkOutput("pending_expected", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
